z80_io_ctrl: RTL

Z80-side I/O controller for the sound subsystem. It sits directly downstream of the Z80 CPU wrapper and consumes its address, data and strobe outputs. It decodes Z80 I/O ports, holds the 68k↔Z80 sound-code and reply latches, and generates the Z80 NMI. It also implements the four ZMC ROM bank windows, producing the sound ROM address and chip selects.

---
 rtl/z80_io_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/z80_io_ctrl.sv
// Z80-side I/O controller for the sound subsystem: port decode, 68k<->Z80
// code/reply latches, NMI generation and the four ZMC ROM bank windows.
module z80_io_ctrl (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] SDA,
    input  logic [7:0]  SDD_OUT,
    input  logic        nIORQ,
    input  logic        nMREQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        M68K_CODE_WR,
    input  logic [7:0]  M68K_CODE,
    output logic [7:0]  REPLY,
    output logic [7:0]  CODE_DOUT,
    output logic        nCODE_OE,
    output logic        nNMI,
    output logic        nYM_CS,
    output logic [1:0]  YM_A,
    output logic        nSDROM,
    output logic        nSDRAM,
    output logic [21:0] MA
);
    localparam logic [1:0] PG_CODE  = 2'b00;
    localparam logic [1:0] PG_YM    = 2'b01;
    localparam logic [1:0] PG_NMI   = 2'b10;
    localparam logic [1:0] PG_REPLY = 2'b11;

    logic            w_io_rd, w_io_wr, w_rd_evt, w_wr_evt;
    logic            w_hi_ram;
    logic [1:0]      w_pg;
    logic            r_rd_idle, r_wr_idle;
    logic            r_nmi_en, r_nmi_pend;
    logic            w_nmi_en_nxt, w_nmi_pend_nxt;
    logic            r_nnmi;
    logic [7:0]      r_reply, r_code;
    logic [3:0][7:0] r_bank;

    assign w_io_rd  = ~nIORQ & ~nRD;
    assign w_io_wr  = ~nIORQ & ~nWR;
    assign w_pg     = SDA[3:2];
    assign w_hi_ram = (SDA[15:11] == 5'b11111);

    // r_*_idle means "strobe condition was false last cycle". It resets to 0 so
    // an access still held when reset is released never counts as a new event.
    assign w_rd_evt = w_io_rd & r_rd_idle;
    assign w_wr_evt = w_io_wr & r_wr_idle;

    always_comb begin
        w_nmi_en_nxt = r_nmi_en;
        if (w_wr_evt && w_pg == PG_NMI)
            w_nmi_en_nxt = ~SDA[4];
    end

    // A 68k code write outranks a simultaneous clearing read.
    always_comb begin
        w_nmi_pend_nxt = r_nmi_pend;
        if (M68K_CODE_WR)
            w_nmi_pend_nxt = 1'b1;
        else if (w_rd_evt && w_pg == PG_CODE)
            w_nmi_pend_nxt = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_rd_idle  <= 1'b0;
            r_wr_idle  <= 1'b0;
            r_nmi_en   <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_nnmi     <= 1'b1;
            r_reply    <= 8'h00;
            r_code     <= 8'h00;
            r_bank     <= {8'h02, 8'h06, 8'h0E, 8'h1E};
        end else begin
            r_rd_idle  <= ~w_io_rd;
            r_wr_idle  <= ~w_io_wr;
            r_nmi_en   <= w_nmi_en_nxt;
            r_nmi_pend <= w_nmi_pend_nxt;
            r_nnmi     <= ~(w_nmi_en_nxt & w_nmi_pend_nxt);
            if (M68K_CODE_WR)
                r_code <= M68K_CODE;
            if (w_wr_evt && w_pg == PG_REPLY)
                r_reply <= SDD_OUT;
            if (w_rd_evt && w_pg == PG_NMI)
                r_bank[SDA[1:0]] <= SDA[15:8];
        end
    end

    // Window size halves per bank: 16K, 8K, 4K, 2K; unused MSBs are zero.
    always_comb begin
        MA = {6'b0, SDA};
        if (SDA[15]) begin
            if (!SDA[14])
                MA = {r_bank[3], SDA[13:0]};
            else if (!SDA[13])
                MA = {1'b0, r_bank[2], SDA[12:0]};
            else if (!SDA[12])
                MA = {2'b0, r_bank[1], SDA[11:0]};
            else if (!SDA[11])
                MA = {3'b0, r_bank[0], SDA[10:0]};
        end
    end

    assign REPLY     = r_reply;
    assign CODE_DOUT = r_code;
    assign nNMI      = r_nnmi;
    assign nCODE_OE  = ~(w_io_rd & (w_pg == PG_CODE));
    assign nYM_CS    = ~(~nIORQ & (w_pg == PG_YM));
    assign YM_A      = SDA[1:0];
    assign nSDRAM    = ~(~nMREQ & w_hi_ram);
    assign nSDROM    = ~(~nMREQ & ~nRD & ~w_hi_ram);
endmodule
